// File: rtl/alu_multiciclo.sv
// alu_multiciclo: execution-stage ALU.
// ADD/SUB/AND/OR/SLT/NOP complete in one cycle. MULT (shift-add) and DIV
// (restoring) iterate one bit per cycle over WIDTH cycles behind a
// start/busy/done handshake. The LO word or quotient goes to result. The HI
// word or remainder goes to hi.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start, aluF, A, B   - operation request, sampled only in IDLE
//   result, hi          - registered LO/HI outputs
//   zero                - combinational, result == 0
//   busy, done          - iteration in progress / one-cycle completion pulse
//   div_by_zero         - registered, set by DIV with B == 0
module alu_multiciclo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       aluF,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_MULT = 3'b101;
  localparam logic [2:0] OP_DIV  = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  // opd_r: multiplicand for MULT, divisor for DIV.
  // acc_r: running HI / partial remainder.
  // lo_r : multiplier shifting out / dividend shifting out, quotient shifting in.
  logic [WIDTH-1:0] opd_r, opd_s;
  logic [WIDTH-1:0] acc_r, acc_s;
  logic [WIDTH-1:0] lo_r, lo_s;
  logic [WIDTH-1:0] result_s, hi_s;
  logic             busy_s, done_s, dbz_s;

  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   div_trial_s;
  logic [WIDTH-1:0] div_diff_s;
  logic             div_ge_s;

  assign zero = (result == {WIDTH{1'b0}});

  // Datapath step terms and FSM next-state / next-output logic.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    opd_s    = opd_r;
    acc_s    = acc_r;
    lo_s     = lo_r;
    result_s = result;
    hi_s     = hi;
    busy_s   = busy;
    done_s   = 1'b0;
    dbz_s    = div_by_zero;

    // Shift-add step: add the multiplicand when the current multiplier LSB is
    // set. Keep the carry so the right shift of {sum, lo} is exact.
    mul_sum_s = {1'b0, acc_r} + (lo_r[0] ? {1'b0, opd_r} : {(WIDTH+1){1'b0}});
    // Restoring step: shift the next dividend bit into the partial remainder.
    // trial < 2*divisor, so the WIDTH-bit difference is exact whenever it is
    // used.
    div_trial_s = {acc_r, lo_r[WIDTH-1]};
    div_ge_s    = (div_trial_s >= {1'b0, opd_r});
    div_diff_s  = div_trial_s[WIDTH-1:0] - opd_r;

    case (state_r)
      IDLE: begin
        if (start) begin
          dbz_s = 1'b0;
          case (aluF)
            OP_ADD: begin
              result_s = A + B;
              done_s   = 1'b1;
            end
            OP_SUB: begin
              result_s = A - B;
              done_s   = 1'b1;
            end
            OP_AND: begin
              result_s = A & B;
              done_s   = 1'b1;
            end
            OP_OR: begin
              result_s = A | B;
              done_s   = 1'b1;
            end
            OP_SLT: begin
              result_s = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
              done_s   = 1'b1;
            end
            OP_MULT: begin
              opd_s   = A;
              lo_s    = B;
              acc_s   = {WIDTH{1'b0}};
              cnt_s   = {CW{1'b0}};
              busy_s  = 1'b1;
              state_s = MUL;
            end
            OP_DIV: begin
              if (B == {WIDTH{1'b0}}) begin
                result_s = {WIDTH{1'b1}};
                hi_s     = A;
                dbz_s    = 1'b1;
                done_s   = 1'b1;
              end else begin
                opd_s   = B;
                lo_s    = A;
                acc_s   = {WIDTH{1'b0}};
                cnt_s   = {CW{1'b0}};
                busy_s  = 1'b1;
                state_s = DIV;
              end
            end
            OP_NOP: begin
              done_s = 1'b1;
            end
            default: begin
              done_s = 1'b0;
            end
          endcase
        end else begin
          done_s = 1'b0;
        end
      end
      MUL: begin
        acc_s = mul_sum_s[WIDTH:1];
        lo_s  = {mul_sum_s[0], lo_r[WIDTH-1:1]};
        if (cnt_r == CNT_LAST) begin
          result_s = lo_s;
          hi_s     = acc_s;
          busy_s   = 1'b0;
          done_s   = 1'b1;
          state_s  = IDLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      DIV: begin
        if (div_ge_s) begin
          acc_s = div_diff_s;
        end else begin
          acc_s = div_trial_s[WIDTH-1:0];
        end
        lo_s = {lo_r[WIDTH-2:0], div_ge_s};
        if (cnt_r == CNT_LAST) begin
          result_s = lo_s;
          hi_s     = acc_s;
          busy_s   = 1'b0;
          done_s   = 1'b1;
          state_s  = IDLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      opd_r       <= {WIDTH{1'b0}};
      acc_r       <= {WIDTH{1'b0}};
      lo_r        <= {WIDTH{1'b0}};
      result      <= {WIDTH{1'b0}};
      hi          <= {WIDTH{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      opd_r       <= opd_s;
      acc_r       <= acc_s;
      lo_r        <= lo_s;
      result      <= result_s;
      hi          <= hi_s;
      busy        <= busy_s;
      done        <= done_s;
      div_by_zero <= dbz_s;
    end
  end

endmodule

// File: tb/tb_alu_multiciclo.sv
module tb_alu_multiciclo;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  aluF;
  logic [31:0] A, B;
  logic [31:0] result, hi;
  logic        zero, busy, done, div_by_zero;

  int tests_run = 0;
  int tests_failed = 0;
  int busy_cnt, lat;
  logic saw_done;

  alu_multiciclo #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .aluF(aluF), .A(A), .B(B),
    .result(result), .hi(hi), .zero(zero), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operation for one edge (E0); returns in the cycle after E0.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    aluF  = op;
    A     = a;
    B     = b;
    tick();
    start = 1'b0;
  endtask

  // Wait for done, counting busy cycles; poke>0 pulses an ADD start at that cycle.
  task automatic wait_done(input int poke, output int bcnt, output int l);
    bcnt = 0;
    l = 1;
    while (!done && l < 100) begin
      if (l == poke) begin
        start = 1'b1; aluF = 3'b000; A = 32'd1; B = 32'd1;
      end else begin
        start = 1'b0;
      end
      if (busy) bcnt++;
      tick();
      l++;
    end
    start = 1'b0;
    check("done_seen", {63'd0, done}, 64'd1);
    check("no_overlap", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; aluF = 3'b111; A = 32'd0; B = 32'd0;
    tick(); tick();
    rst = 1'b0;
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    check("rst_zero", {63'd0, zero}, 64'd1);

    // ADD 5+7
    issue(3'b000, 32'd5, 32'd7);
    check("add_done", {63'd0, done}, 64'd1);
    check("add_busy", {63'd0, busy}, 64'd0);
    check("add_result", {32'd0, result}, 64'd12);
    check("add_zero", {63'd0, zero}, 64'd0);
    tick();
    check("add_done_drop", {63'd0, done}, 64'd0);

    issue(3'b001, 32'd3, 32'd3);
    check("sub_result", {32'd0, result}, 64'd0);
    check("sub_zero", {63'd0, zero}, 64'd1);
    issue(3'b100, 32'hFFFF_FFFF, 32'd1);
    check("slt_neg", {32'd0, result}, 64'd1);
    issue(3'b100, 32'd1, 32'hFFFF_FFFF);
    check("slt_pos", {32'd0, result}, 64'd0);
    issue(3'b010, 32'h0000_F0F0, 32'h0000_FF00);
    check("and_result", {32'd0, result}, 64'h0000_F000);
    issue(3'b011, 32'h0000_F0F0, 32'h0000_FF00);
    check("or_result", {32'd0, result}, 64'h0000_FFF0);
    issue(3'b111, 32'd9, 32'd9);
    check("nop_done", {63'd0, done}, 64'd1);
    check("nop_result", {32'd0, result}, 64'h0000_FFF0);

    // MULT with an ignored ADD start during busy
    issue(3'b101, 32'hFFFF_FFFF, 32'd2);
    wait_done(5, busy_cnt, lat);
    check("mul_lat", 64'(lat), 64'd33);
    check("mul_busy_cycles", 64'(busy_cnt), 64'd32);
    check("mul_lo_hi", {hi, result}, 64'h0000_0001_FFFF_FFFE);
    tick();
    check("mul_ignored_start", {63'd0, done}, 64'd0);
    check("mul_hold", {hi, result}, 64'h0000_0001_FFFF_FFFE);

    issue(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(0, busy_cnt, lat);
    check("mul_max", {hi, result}, 64'hFFFF_FFFE_0000_0001);

    // DIV
    issue(3'b110, 32'd100, 32'd7);
    wait_done(0, busy_cnt, lat);
    check("div_lat", 64'(lat), 64'd33);
    check("div_busy_cycles", 64'(busy_cnt), 64'd32);
    check("div_q_r", {hi, result}, {32'd2, 32'd14});
    issue(3'b110, 32'hFFFF_FFFF, 32'h0000_0010);
    wait_done(0, busy_cnt, lat);
    check("div_big", {hi, result}, {32'h0000_000F, 32'h0FFF_FFFF});

    issue(3'b110, 32'd9, 32'd0);
    check("dbz_done", {63'd0, done}, 64'd1);
    check("dbz_busy", {63'd0, busy}, 64'd0);
    check("dbz_q_r", {hi, result}, {32'd9, 32'hFFFF_FFFF});
    check("dbz_flag", {63'd0, div_by_zero}, 64'd1);
    tick();
    check("dbz_hold", {63'd0, div_by_zero}, 64'd1);
    check("dbz_done_drop", {63'd0, done}, 64'd0);
    issue(3'b000, 32'd1, 32'd1);
    check("dbz_cleared", {63'd0, div_by_zero}, 64'd0);
    check("add_after_dbz", {hi, result}, {32'd9, 32'd2});

    // Reset in the middle of a MULT
    issue(3'b101, 32'd6, 32'd7);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_regs", {hi, result}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    check("abort_no_done", {63'd0, saw_done}, 64'd0);
    issue(3'b101, 32'd6, 32'd7);
    wait_done(0, busy_cnt, lat);
    check("mul_after_abort", {hi, result}, 64'd42);

    // Back-to-back: start held, operands switched to ADD 1+1 after E0
    issue(3'b101, 32'd3, 32'd4);
    start = 1'b1; aluF = 3'b000; A = 32'd1; B = 32'd1;
    lat = 1;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    check("b2b_mul_lat", 64'(lat), 64'd33);
    check("b2b_mul", {32'd0, result}, 64'd12);
    tick();
    start = 1'b0;
    check("b2b_add_done", {63'd0, done}, 64'd1);
    check("b2b_add", {32'd0, result}, 64'd2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_multiciclo.md
Name: alu_multiciclo

Overview:
- Execution-stage ALU that consumes the 3-bit operation code `aluF` produced by the ALU control stage.
- Executes ADD, SUB, AND, OR, SLT and NOP in one cycle.
- Executes MULT and DIV iteratively over WIDTH cycles, using a start/busy/done handshake toward the pipeline controller.
- Products and quotients go to `result`. High product word and remainder go to `hi`, as in the MIPS HI/LO pair.

Parameters:
- WIDTH, 32, operand and result width in bits. Must be ≥ 2.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to execute `aluF` on A and B. Sampled only in IDLE.
- aluF  input  3  operation code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 MULT, 110 DIV, 111 NOP.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- result  output  WIDTH  registered result (LO word for MULT, quotient for DIV).
- hi  output  WIDTH  registered HI word (MULT upper half, DIV remainder).
- zero  output  1  combinational; 1 when `result` == 0.
- busy  output  1  1 while a MULT/DIV iteration is in progress.
- done  output  1  one-cycle pulse when an operation completes.
- div_by_zero  output  1  registered flag, set by a DIV with B == 0.

Behaviour:
- Reset (rst=1 at an edge):
  - Clears `result`, `hi`, `done`, `busy`, `div_by_zero` to 0 and the iteration counter to 0.
  - Returns the FSM to IDLE.
  - Reset mid-MULT/DIV aborts the operation; no `done` is produced.
  - rst has priority over start.
- FSM states are IDLE, MUL, DIV. Edge E0 is the first edge at which start=1 is sampled in IDLE.
- Single-cycle ops at E0:
  - ADD: result = A+B mod 2^WIDTH.
  - SUB: result = A−B mod 2^WIDTH.
  - AND/OR: bitwise.
  - SLT: result = 1 if $signed(A) < $signed(B), else 0.
  - NOP: `result` unchanged.
  - All of these leave `hi` unchanged, set done=1, and stay in IDLE.
  - Latency: `done` is visible for exactly the one cycle after E0.
- MULT at E0:
  - Latch A and B; clear the accumulator and counter; go to MUL with busy=1.
  - Unsigned shift-add, one multiplier bit per edge, on edges E1..E_WIDTH.
  - At E_WIDTH: {hi, result} = A*B (2·WIDTH-bit unsigned), busy=0, done=1, return to IDLE.
- DIV at E0 with B ≠ 0:
  - Latch operands; go to DIV with busy=1.
  - Unsigned restoring division, one quotient bit per edge, on edges E1..E_WIDTH.
  - At E_WIDTH: result = A/B, hi = A%B, done=1, busy=0, return to IDLE.
- DIV at E0 with B == 0:
  - No iteration.
  - result = all ones, hi = A, div_by_zero=1, done=1 for the cycle after E0.
- div_by_zero:
  - Cleared at the next accepted start of any operation.
  - Otherwise holds its value.
- Handshake rules:
  - `busy` is high for exactly WIDTH cycles, from after E0 to after E_WIDTH−1.
  - `done` and `busy` are never high together.
  - start while busy=1 is ignored; the in-flight operation is unaffected.
  - start in the done cycle is accepted, so back-to-back operations are allowed.
  - A and B may change after E0 without affecting an in-flight MULT/DIV.
- `result` and `hi` hold their values between completions.
- Operands and results carry no overflow/carry flag; wrap-around is silent.
- `done` is deasserted in every cycle except the single completion cycle.

Test Plan (all with WIDTH=32):
- Reset, then ADD A=5, B=7 → result=12, zero=0, done high one cycle after start, busy never high.
- SUB A=3, B=3 → result=0, zero=1. Then SLT A=0xFFFFFFFF, B=1 → result=1. Then SLT A=1, B=0xFFFFFFFF → result=0.
- MULT A=0xFFFFFFFF, B=2 → busy high 32 cycles, done on the 33rd cycle after start, result=0xFFFFFFFE, hi=0x00000001. During busy, pulse start with ADD → ignored; results unchanged.
- DIV A=100, B=7 → result=14, hi=2, 33-cycle latency. Then DIV A=9, B=0 → one-cycle done, result=0xFFFFFFFF, hi=9, div_by_zero=1. Then ADD 1+1 → div_by_zero cleared, result=2.
- Start MULT A=6, B=7; assert rst at cycle 10 → result=0, hi=0, busy=0, no done. Then MULT 6×7 → result=42, hi=0.
- Back-to-back: MULT 3×4 with start held through the done cycle and aluF=000, A=1, B=1 → done cycle shows 12, next done shows 2.
